// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide (shift-add / restoring radix-2) with valid/ready handshakes.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply, divides stay iterative.
module muldiv_unit #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op,
  input  logic [DW-1:0] operand_a,
  input  logic [DW-1:0] operand_b,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] result
);
  localparam int CW = $clog2(DW) + 1;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t          r_state, w_next;
  logic [2:0]      r_op;
  logic            r_neg_a, r_neg_b;
  logic [DW-1:0]   r_m;
  logic [2*DW-1:0] r_prod;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_result;
  logic            w_sgn_a, w_sgn_b, w_neg_a, w_neg_b, w_div0, w_ovf, w_special, w_accept, w_fast, w_neg_p;
  logic [DW-1:0]   w_mag_a, w_mag_b, w_special_res, w_fast_res, w_quo, w_rem, w_fix_res;
  logic [DW:0]     w_sum, w_trial, w_diff;
  logic [2*DW-1:0] w_step, w_prod_s;
  assign w_sgn_a       = op[2] ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
  assign w_sgn_b       = op[2] ? ~op[0] : (op[1:0] == 2'b01);
  assign w_neg_a       = w_sgn_a & operand_a[DW-1];
  assign w_neg_b       = w_sgn_b & operand_b[DW-1];
  assign w_mag_a       = w_neg_a ? -operand_a : operand_a;
  assign w_mag_b       = w_neg_b ? -operand_b : operand_b;
  assign w_div0        = op[2] & (operand_b == '0);
  assign w_ovf         = op[2] & ~op[0] & (operand_a == {1'b1, {(DW-1){1'b0}}}) & (&operand_b);
  assign w_special     = w_div0 | w_ovf;
  assign w_special_res = w_div0 ? (op[1] ? operand_a : '1) : (op[1] ? '0 : operand_a);
  assign w_accept      = (r_state == IDLE) & in_valid & ~flush;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*DW-1:0] w_fa, w_fb, w_fast_prod;
  assign w_fa        = {{DW{w_neg_a}}, operand_a};
  assign w_fb        = {{DW{w_neg_b}}, operand_b};
  assign w_fast_prod = w_fa * w_fb;
  assign w_fast      = ~op[2];
  assign w_fast_res  = (op[1:0] == 2'b00) ? w_fast_prod[DW-1:0] : w_fast_prod[2*DW-1:DW];
`else
  assign w_fast      = 1'b0;
  assign w_fast_res  = '0;
`endif
  // Multiply: upper half accumulates, lower half holds the multiplier. Divide: upper = remainder, lower = dividend/quotient.
  assign w_sum    = {1'b0, r_prod[2*DW-1:DW]} + (r_prod[0] ? {1'b0, r_m} : '0);
  assign w_trial  = {r_prod[2*DW-1:DW], r_prod[DW-1]};
  assign w_diff   = w_trial - {1'b0, r_m};
  assign w_step   = r_op[2] ? {(w_diff[DW] ? w_trial[DW-1:0] : w_diff[DW-1:0]), r_prod[DW-2:0], ~w_diff[DW]}
                            : {w_sum, r_prod[DW-1:1]};
  assign w_neg_p  = r_neg_a ^ r_neg_b;
  assign w_prod_s = w_neg_p ? -r_prod : r_prod;
  assign w_quo    = r_prod[DW-1:0];
  assign w_rem    = r_prod[2*DW-1:DW];
  assign w_fix_res = ~r_op[2] ? ((r_op[1:0] == 2'b00) ? w_prod_s[DW-1:0] : w_prod_s[2*DW-1:DW])
                   : r_op[1]  ? (r_neg_a ? -w_rem : w_rem)
                   : (w_neg_p ? -w_quo : w_quo);
  always_comb begin
    w_next = r_state;
    if (flush) w_next = IDLE;
    else
      case (r_state)
        IDLE:    if (in_valid) w_next = (w_special | w_fast) ? DONE : CALC;
        CALC:    if (r_cnt == CW'(DW - 1)) w_next = FIX;
        FIX:     w_next = DONE;
        DONE:    if (out_ready) w_next = IDLE;
        default: w_next = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_m      <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op    <= op;
        r_neg_a <= w_neg_a;
        r_neg_b <= w_neg_b;
        r_m     <= op[2] ? w_mag_b : w_mag_a;
        r_prod  <= {{DW{1'b0}}, op[2] ? w_mag_a : w_mag_b};
        r_cnt   <= '0;
        if (w_special | w_fast) r_result <= w_special ? w_special_res : w_fast_res;
      end
      if (r_state == CALC) begin
        r_prod <= w_step;
        r_cnt  <= r_cnt + CW'(1);
      end
      if (r_state == FIX) r_result <= w_fix_res;
    end
  end
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed + random checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int DW = 32;
  logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid;
  logic [2:0]    op = '0;
  logic [DW-1:0] a = '0, b = '0, result;
  int            n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  muldiv_unit #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .operand_a(a), .operand_b(b), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint p;
    int     sx, sy;
    logic   ovf;
    sx  = x;
    sy  = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = longint'(x) * longint'(y); return p[31:0]; end
      3'd1: begin p = longint'(sx) * longint'(sy); return p[63:32]; end
      3'd2: begin p = longint'(sx) * longint'({32'b0, y}); return p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return x;
        return 32'(sx / sy);
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        return x / y;
      end
      3'd6: begin
        if (y == 0) return x;
        if (ovf) return 32'h0;
        return 32'(sx % sy);
      end
      default: begin
        if (y == 0) return x;
        return x % y;
      end
    endcase
  endfunction
  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!o[2]) return 1;
`endif
    return DW + 2;
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int hold, input string tag);
    logic [31:0] exp;
    int          lat, el;
    exp = model(o, x, y);
    el  = exp_lat(o, x, y);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(el));
    chk({tag, " result"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, " held result"}, result, exp);
      chk({tag, " held out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " held in_ready"}, 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " out_valid after take"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready after take"}, 32'(in_ready), 32'd1);
  endtask
  initial begin
    logic seen;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, "mul");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, "mulh");
    run_op(3'd2, 32'h8000_0000, 32'h8000_0000, 0, "mulhsu");
    run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 0, "mulhu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, "div");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, "rem");
    run_op(3'd5, 32'd100, 32'd7, 0, "divu");
    run_op(3'd7, 32'd100, 32'd7, 0, "remu");
    run_op(3'd4, 32'd5, 32'd0, 0, "div by zero");
    run_op(3'd6, 32'd5, 32'd0, 0, "rem by zero");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div overflow");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem overflow");
    run_op(3'd4, 32'd1000, 32'd7, 5, "stall");
    @(negedge clk);
    op = 3'd4; a = $urandom; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = out_valid;
    repeat (9) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush in_ready", 32'(in_ready), 32'd1);
    chk("flush out_valid", 32'(out_valid), 32'd0);
    repeat (DW) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    chk("flush never valid", 32'(seen), 32'd0);
    run_op(3'd5, 32'd123456, 32'd789, 0, "divu after flush");
    @(negedge clk);
    op = 3'd4; a = $urandom; b = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 32'(out_valid), 32'd0);
    chk("async reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu after reset");
    for (int i = 0; i < 48; i++) run_op(3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(0, 2), "random");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle integer multiply/divide unit implementing the eight RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for a parametrised data width. It sits in the execute stage beside the single-cycle ALU. The pipeline launches an operation through a valid/ready handshake, stalls while the unit is busy, and collects the result through a second handshake. A pipeline flush aborts an operation in flight.

## Interface
- DW, 32, operand/result width; must be even and ≥ 4.
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept a request (high in IDLE only).
- op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a  input  DW  rs1 value (dividend / multiplicand).
- operand_b  input  DW  rs2 value (divisor / multiplier).
- flush  input  1  synchronous abort of any operation in flight.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- result  output  DW  operation result, held stable while out_valid && !out_ready.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1. On in_valid, latch op and operands; signed ops record operand signs and convert operands to magnitudes. MULHSU treats a as signed and b as unsigned.
  - Div-by-zero: go directly to DONE. DIV/DIVU give all-ones; REM/REMU give operand_a.
  - Signed overflow (DIV/REM with a = 2^(DW-1), b = all-ones): go directly to DONE. DIV gives operand_a; REM gives 0.
  - All other cases go to CALC with the iteration counter (width $clog2(DW)+1) cleared.
- CALC: one iteration per cycle for exactly DW cycles, then FIX.
  - Multiply: shift-add into a 2·DW-bit product register.
  - Divide: restoring radix-2, one quotient bit per cycle, with a DW-bit partial remainder.
- FIX: apply signs.
  - Product is negated when exactly one signed operand was negative.
  - Quotient is negated when dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - Select the result: low DW bits for MUL; high DW bits for MULH/MULHSU/MULHU; quotient or remainder for the divide ops. Go to DONE.
- DONE: out_valid=1 and result stable. On out_ready go to IDLE.
- flush: in any state, next state is IDLE, out_valid drops next cycle and the result is discarded. flush takes priority over acceptance in IDLE and over out_ready in DONE.
- Arithmetic wraps modulo 2^DW or 2^(2·DW); no exceptions are raised.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, counter=0. Reset asserted mid-operation aborts it immediately.
- Acceptance edge T (in_valid && in_ready):
  - Normal path: CALC for cycles T+1..T+DW, FIX at T+DW+1, out_valid from T+DW+2. Latency is DW+2 cycles (34 for DW=32).
  - Div-by-zero and overflow: out_valid from T+1.
- out_valid stays high until the out_ready edge; state is IDLE and in_ready high on the following cycle. There is no back-to-back acceptance in DONE, so minimum issue interval is latency+1.
- Operands and op are sampled only at acceptance. Later input changes have no effect.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - The four multiply ops skip CALC and FIX. The full signed/unsigned 2·DW product is computed combinationally from the latched operands and registered, so out_valid is high at T+1.
  - Divide ops are unchanged.
- Undefined: multiplies use the iterative path with DW+2 latency.

## Test plan
- Reset then MUL a=7, b=-3 (0xFFFFFFFD), DW=32 → result 0xFFFFFFEB (-21). out_valid at T+34 (T+1 with MULDIV_FAST_MUL_EN).
- MULH/MULHSU/MULHU with a=b=0x80000000 → 0x40000000 / 0xC0000000 / 0x40000000.
- DIV a=-7, b=2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU a=100, b=7 → 14; REMU same operands → 2.
- DIV a=5, b=0 → 0xFFFFFFFF; REM a=5, b=0 → 5; DIV a=0x80000000, b=-1 → 0x80000000; REM same operands → 0. Each with out_valid at T+1.
- Handshake and flush:
  - out_ready held low for 5 cycles → result stable and out_valid high throughout, in_ready low.
  - flush at T+10 of a DIV → out_valid never asserts, in_ready high at T+11, and a new DIVU accepted then completes correctly.
- rst_n pulsed low mid-CALC → out_valid=0 and in_ready=1 immediately. The next operation MULHU 0xFFFFFFFF×0xFFFFFFFF returns 0xFFFFFFFE.
